store_buffer: RTL and testbench

//  In-order store queue between the execute stage and the word-addressed 16-bit data memory.

---
 rtl/store_buffer_pkg.sv | 21 ++
 rtl/sb_match.sv | 30 +++
 rtl/store_buffer.sv | 98 +++++++++
 tb/tb_store_buffer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared sizes, queue entry type and port-select encoding for the store buffer.
// DEPTH/AW/DW are the build-time geometry of the buffer; sb_entry_t is sized from them.
package store_buffer_pkg;

    localparam int DEPTH = 4;
    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } sb_entry_t;

    typedef enum logic [1:0] {
        SB_IDLE  = 2'd0,
        SB_LOAD  = 2'd1,
        SB_DRAIN = 2'd2
    } sb_sel_t;

endpackage

// File: rtl/sb_match.sv
// sb_match: compares a load address with every valid queued store and picks the youngest match.
// Youngest means nearest to the tail pointer, so forwarding returns the last store in program order.
module sb_match
    import store_buffer_pkg::*;
(
    input  logic [AW-1:0]    i_addr [DEPTH],
    input  logic [DEPTH-1:0] i_valid,
    input  logic [PTR_W-1:0] i_tail,
    input  logic [AW-1:0]    i_ld_addr,
    output logic             o_hit,
    output logic [PTR_W-1:0] o_index
);

    logic [PTR_W-1:0] w_idx;

    // Walk entries oldest to youngest relative to tail; a later (younger) match overrides earlier ones.
    always_comb begin
        o_hit   = 1'b0;
        o_index = '0;
        w_idx   = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            w_idx = i_tail - PTR_W'(k);
            if (i_valid[w_idx] && (i_addr[w_idx] == i_ld_addr)) begin
                o_hit   = 1'b1;
                o_index = w_idx;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: in-order store queue in front of the word-addressed data memory, drained one store per idle cycle.
// Loads own the memory port when present; a load matching a queued store is either forwarded
// (STORE_BUF_FWD_EN defined) or held off while the queue drains until no match remains (default).
module store_buffer
    import store_buffer_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_st_valid,
    output logic          o_st_ready,
    input  logic [AW-1:0] i_st_addr,
    input  logic [DW-1:0] i_st_data,
    input  logic          i_ld_valid,
    output logic          o_ld_ready,
    input  logic [AW-1:0] i_ld_addr,
    output logic [DW-1:0] o_ld_data,
    output logic          o_mem_read,
    output logic          o_mem_write,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata,
    output logic          o_empty
);

    sb_entry_t        r_buf [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    logic [AW-1:0]    w_addrs [DEPTH];
    logic             w_hit;
    logic [PTR_W-1:0] w_idx;
    logic             w_ld_go;
    logic             w_enq;
    logic             w_drain;
    sb_sel_t          w_sel;

    for (genvar i = 0; i < DEPTH; i++) begin : g_addr
        assign w_addrs[i] = r_buf[i].addr;
    end

    sb_match u_match (
        .i_addr    (w_addrs),
        .i_valid   (r_valid),
        .i_tail    (r_tail),
        .i_ld_addr (i_ld_addr),
        .o_hit     (w_hit),
        .o_index   (w_idx)
    );

`ifdef STORE_BUF_FWD_EN
    assign w_ld_go = i_ld_valid;
`else
    assign w_ld_go = i_ld_valid && !w_hit;
`endif

    // Port arbitration: a serviceable load wins, otherwise drain the oldest entry if any.
    always_comb begin
        w_sel       = w_ld_go ? SB_LOAD : (r_count != '0) ? SB_DRAIN : SB_IDLE;
        w_drain     = (w_sel == SB_DRAIN);
        w_enq       = i_st_valid && o_st_ready;
        o_st_ready  = (r_count != (PTR_W+1)'(DEPTH));
        o_empty     = (r_count == '0);
        o_ld_ready  = w_ld_go;
        o_ld_data   = w_ld_go ? (w_hit ? r_buf[w_idx].data : i_mem_rdata) : '0;
        o_mem_read  = (w_sel == SB_LOAD);
        o_mem_write = w_drain;
        o_mem_addr  = (w_sel == SB_LOAD) ? i_ld_addr : w_drain ? r_buf[r_head].addr : '0;
        o_mem_wdata = w_drain ? r_buf[r_head].data : '0;
    end

    // Entry payload needs no reset: r_valid and the pointers define what is live.
    always_ff @(posedge clk) begin
        if (w_enq) r_buf[r_tail] <= {i_st_addr, i_st_data};
    end

    // Queue bookkeeping; enqueue and drain never touch the same slot because a full queue refuses stores.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PTR_W'(1);
            end
            if (w_drain) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
            r_count <= r_count + (PTR_W+1)'(w_enq) - (PTR_W+1)'(w_drain);
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: randomized and directed stimulus for store_buffer against a queue-based reference model.
module tb_store_buffer;
    import store_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st_valid = 1'b0, st_ready;
    logic [15:0] st_addr = '0, st_data = '0;
    logic        ld_valid = 1'b0, ld_ready;
    logic [15:0] ld_addr = '0, ld_data;
    logic        mem_read, mem_write, empty;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    typedef struct packed {
        logic        st_ready;
        logic        ld_ready;
        logic [15:0] ld_data;
        logic        mem_read;
        logic        mem_write;
        logic [15:0] mem_addr;
        logic [15:0] mem_wdata;
        logic        empty;
    } out_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } st_t;

    out_t        got, exp_o;
    st_t         q[$];
    logic [15:0] ref_mem [int];
    logic [15:0] mem [0:65535];
    bit          p_valid, p_drain, p_enq;
    st_t         p_st;
    int          n_vec = 0, n_err = 0;

    store_buffer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_st_valid  (st_valid),
        .o_st_ready  (st_ready),
        .i_st_addr   (st_addr),
        .i_st_data   (st_data),
        .i_ld_valid  (ld_valid),
        .o_ld_ready  (ld_ready),
        .i_ld_addr   (ld_addr),
        .o_ld_data   (ld_data),
        .o_mem_read  (mem_read),
        .o_mem_write (mem_write),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .o_empty     (empty)
    );

    always #5 clk = ~clk;

    assign got = {st_ready, ld_ready, ld_data, mem_read, mem_write, mem_addr, mem_wdata, empty};
    assign mem_rdata = mem[mem_addr];

    function automatic logic [15:0] init_word(int a);
        return 16'(a) ^ 16'h5A5A;
    endfunction

    initial for (int i = 0; i < 65536; i++) mem[i] <= init_word(i);

    always @(negedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

    function automatic logic [15:0] ref_rd(logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(int'(a));
    endfunction

    function automatic out_t model(bit ldv, logic [15:0] la);
        out_t        e;
        bit          hit = 1'b0;
        bit          go, dr;
        logic [15:0] hd = '0;
        foreach (q[i]) if (q[i].a == la) begin hit = 1'b1; hd = q[i].d; end
`ifdef STORE_BUF_FWD_EN
        go = ldv;
`else
        go = ldv && !hit;
`endif
        dr = !go && (q.size() > 0);
        e.st_ready  = q.size() < DEPTH;
        e.ld_ready  = go;
        e.ld_data   = go ? (hit ? hd : ref_rd(la)) : 16'h0;
        e.mem_read  = go;
        e.mem_write = dr;
        e.mem_addr  = go ? la : dr ? q[0].a : 16'h0;
        e.mem_wdata = dr ? q[0].d : 16'h0;
        e.empty     = q.size() == 0;
        return e;
    endfunction

    task automatic step(input bit stv, input logic [15:0] sa, input logic [15:0] sd,
                        input bit ldv, input logic [15:0] la);
        @(posedge clk);
        if (p_valid) begin
            if (p_drain) begin ref_mem[int'(q[0].a)] = q[0].d; void'(q.pop_front()); end
            if (p_enq) q.push_back(p_st);
        end
        p_valid = 1'b0;
        #1;
        st_valid = stv; st_addr = sa; st_data = sd; ld_valid = ldv; ld_addr = la;
        #2;
        exp_o   = model(ldv, la);
        p_drain = exp_o.mem_write;
        p_enq   = stv && (q.size() < DEPTH);
        p_st    = '{sa, sd};
        p_valid = 1'b1;
    endtask

    task automatic do_reset();
        st_valid = 1'b0; ld_valid = 1'b0;
        rst_n = 1'b0;
        q.delete();
        p_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        exp_o = model(1'b0, 16'h0);
        n_vec++;
        if (got !== exp_o) begin n_err++; $display("FAIL reset: got %h expected %h", got, exp_o); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_fill_full();
        for (int i = 0; i < 9; i++) begin
            if (i < 4)       step(1'b1, 16'h10 + 16'(i), 16'(16'h1111 * (i + 1)), 1'b1, 16'h100);
            else if (i == 4) step(1'b1, 16'h14, 16'h5555, 1'b1, 16'h100);
            else if (i < 7)  step(1'b1, 16'h14, 16'h5555, 1'b0, 16'h0);
            else             step(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
            n_vec++;
            if (got !== exp_o) begin n_err++; $display("FAIL fill_full[%0d]: got %h expected %h", i, got, exp_o); end
        end
        repeat (4) step(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (mem[16'h10 + 16'(i)] !== 16'(16'h1111 * (i + 1))) begin
                n_err++;
                $display("FAIL fill_mem[%0d]: got %h expected %h", i, mem[16'h10 + 16'(i)], 16'(16'h1111 * (i + 1)));
            end
        end
    endtask

    task automatic test_same_addr();
        for (int i = 0; i < 9; i++) begin
            if (i < 2)      step(1'b1, 16'h20, (i == 0) ? 16'hAAAA : 16'hBBBB, 1'b1, 16'h101);
            else if (i < 5) step(1'b0, 16'h0, 16'h0, 1'b1, 16'h20);
            else            step(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
            n_vec++;
            if (got !== exp_o) begin n_err++; $display("FAIL same_addr[%0d]: got %h expected %h", i, got, exp_o); end
        end
        n_vec++;
        if (mem[16'h20] !== 16'hBBBB) begin n_err++; $display("FAIL same_addr_mem: got %h expected bbbb", mem[16'h20]); end
    endtask

    task automatic test_load_miss();
        for (int i = 0; i < 6; i++) begin
            if (i < 2)       step(1'b1, 16'h31 + 16'(i), (i == 0) ? 16'h1234 : 16'h5678, 1'b1, 16'h102);
            else if (i == 2) step(1'b0, 16'h0, 16'h0, 1'b1, 16'h30);
            else             step(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
            n_vec++;
            if (got !== exp_o) begin n_err++; $display("FAIL load_miss[%0d]: got %h expected %h", i, got, exp_o); end
        end
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) step(1'b1, 16'h50 + 16'(i), 16'hC000 + 16'(i), 1'b1, 16'h103);
            else       step(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
            n_vec++;
            if (got !== exp_o) begin n_err++; $display("FAIL mid_drain[%0d]: got %h expected %h", i, got, exp_o); end
        end
        #1 do_reset();
        #1;
        exp_o = model(1'b0, 16'h0);
        n_vec++;
        if (got !== exp_o) begin n_err++; $display("FAIL mid_reset: got %h expected %h", got, exp_o); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
            n_vec++;
            if (got !== exp_o) begin n_err++; $display("FAIL post_reset[%0d]: got %h expected %h", i, got, exp_o); end
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (mem[16'h50 + 16'(i)] !== init_word(16'h50 + i)) begin
                n_err++;
                $display("FAIL discard_mem[%0d]: got %h expected %h", i, mem[16'h50 + 16'(i)], init_word(16'h50 + i));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(99) < 55, 16'h40 + 16'($urandom_range(7)), 16'($urandom),
                 $urandom_range(99) < 45, 16'h40 + 16'($urandom_range(8)));
            n_vec++;
            if (got !== exp_o) begin n_err++; $display("FAIL random[%0d]: got %h expected %h", i, got, exp_o); end
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
            n_vec++;
            if (got !== exp_o) begin n_err++; $display("FAIL random_drain[%0d]: got %h expected %h", i, got, exp_o); end
        end
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (mem[16'h40 + 16'(i)] !== ref_rd(16'h40 + 16'(i))) begin
                n_err++;
                $display("FAIL random_mem[%0d]: got %h expected %h", i, mem[16'h40 + 16'(i)], ref_rd(16'h40 + 16'(i)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_full();
        test_same_addr();
        test_load_miss();
        test_reset_mid_drain();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
